// File: rtl/cep_define.sv
// rtl/cep_define.sv - shared types, encodings and helpers for the PMP checker
package cep_define;

  // Address-matching mode of a PMP entry
  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  // Access type being checked
  typedef enum logic [1:0] {
    OPER_READ  = 2'd0,
    OPER_WRITE = 2'd1,
    OPER_EXEC  = 2'd2
  } pmp_oper_e;

  // Request sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } pmp_state_e;

  // Stored cfg bits; cfg byte bits [6:5] are never kept, so they are not held here
  typedef struct packed {
    logic   l;
    pmp_a_e a;
    logic   x;
    logic   w;
    logic   r;
  } pmpcfg_t;

  localparam logic [7:0] CSR_PMPCFG_HI  = 8'h3A;
  localparam logic [7:0] CSR_PMPADDR_HI = 8'h3B;
  localparam logic [1:0] PRIV_M         = 2'd3;
  localparam logic [1:0] OPER_INVALID   = 2'd3;
  localparam logic [1:0] PERM_GRANT     = 2'b11;

  // Architectural byte image of a stored cfg entry
  function automatic logic [7:0] cfg_to_byte(input pmpcfg_t c);
    return {c.l, 2'b00, c.a, c.x, c.w, c.r};
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// rtl/pmp_entry_match.sv - single PMP entry range check (NAPOT gated by PMP_NAPOT_EN)
module pmp_entry_match
  import cep_define::*;
(
  input  pmp_a_e      a_i,
  input  logic [31:0] pmpaddr_i,
  input  logic [31:0] pmpaddr_lo_i,
  input  logic [31:0] first_i,
  input  logic [31:0] last_i,
  output logic        match_o,
  output logic        partial_o
);

  // TOR bounds live in a 34-bit byte space because pmpaddr holds addr[33:2]
  logic [33:0] tor_lo;
  logic [33:0] tor_hi;
  logic [33:0] first_ext;
  logic [33:0] last_ext;
  logic        first_tor, last_tor;
  logic        first_na4, last_na4;
  logic        first_napot, last_napot;
  logic        hit_first, hit_last;

  assign tor_lo    = {pmpaddr_lo_i, 2'b00};
  assign tor_hi    = {pmpaddr_i, 2'b00};
  assign first_ext = {2'b00, first_i};
  assign last_ext  = {2'b00, last_i};

  assign first_tor = (first_ext >= tor_lo) && (first_ext < tor_hi);
  assign last_tor  = (last_ext >= tor_lo) && (last_ext < tor_hi);

  assign first_na4 = (first_i[31:2] == pmpaddr_i[29:0]);
  assign last_na4  = (last_i[31:2] == pmpaddr_i[29:0]);

`ifdef PMP_NAPOT_EN
  // Trailing ones plus the first zero form the word-address don't-care mask
  logic [31:0] napot_mask;
  assign napot_mask  = pmpaddr_i ^ (pmpaddr_i + 32'd1);
  assign first_napot = (({2'b00, first_i[31:2]} & ~napot_mask) == (pmpaddr_i & ~napot_mask));
  assign last_napot  = (({2'b00, last_i[31:2]} & ~napot_mask) == (pmpaddr_i & ~napot_mask));
`else
  // NAPOT entries are stored but behave as OFF in this build
  assign first_napot = 1'b0;
  assign last_napot  = 1'b0;
`endif

  // Select the per-byte hit for the entry's matching mode
  always_comb begin
    hit_first = 1'b0;
    hit_last  = 1'b0;
    case (a_i)
      A_TOR: begin
        hit_first = first_tor;
        hit_last  = last_tor;
      end
      A_NA4: begin
        hit_first = first_na4;
        hit_last  = last_na4;
      end
      A_NAPOT: begin
        hit_first = first_napot;
        hit_last  = last_napot;
      end
      default: begin
        hit_first = 1'b0;
        hit_last  = 1'b0;
      end
    endcase
  end

  assign match_o   = hit_first & hit_last;
  assign partial_o = hit_first ^ hit_last;

endmodule

// File: rtl/pmp_check_seq.sv
// rtl/pmp_check_seq.sv - sequential PMP checker, one entry per cycle; NAPOT matching enabled by PMP_NAPOT_EN
module pmp_check_seq
  import cep_define::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [1:0]  csr_priv,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_err,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_oper,
  input  logic [1:0]  req_priv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_perm,
  output logic [4:0]  rsp_entry
);

  localparam int              IW       = $clog2(NUM_ENTRIES);
  localparam logic [4:0]      NO_ENTRY = 5'(NUM_ENTRIES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_ENTRIES - 1);

  pmp_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    oper_q, oper_d;
  logic [1:0]    priv_q, priv_d;
  logic [1:0]    perm_q, perm_d;
  logic [4:0]    entry_q, entry_d;
  logic          csr_err_q, csr_err_d;

  pmpcfg_t       cfg_q   [NUM_ENTRIES];
  pmpcfg_t       cfg_d   [NUM_ENTRIES];
  logic [31:0]   paddr_q [NUM_ENTRIES];
  logic [31:0]   paddr_d [NUM_ENTRIES];

  logic                   csr_is_cfg, csr_is_addr, csr_wr_ok;
  logic [NUM_ENTRIES-1:0] addr_lock;

  pmpcfg_t     cur_cfg;
  logic [31:0] cur_addr, cur_lo, last_byte;
  logic        cur_match, cur_partial, perm_bit, grant;
  logic        accept;

  // ---------------------------------------------------------------------------
  // CSR access
  // ---------------------------------------------------------------------------
  assign csr_is_cfg  = (csr_addr[11:4] == CSR_PMPCFG_HI);
  assign csr_is_addr = (csr_addr[11:4] == CSR_PMPADDR_HI);
  assign csr_wr_ok   = csr_we && (state_q == ST_IDLE) && (csr_priv == PRIV_M);
  assign csr_err_d   = csr_we && !csr_wr_ok;

  // An address is frozen by its own lock, or by a locked TOR entry above it
  always_comb begin
    addr_lock = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      addr_lock[k] = cfg_q[k].l;
    end
    for (int k = 1; k < NUM_ENTRIES; k++) begin
      if (cfg_q[k].l && (cfg_q[k].a == A_TOR)) begin
        addr_lock[k-1] = 1'b1;
      end
    end
  end

  // Accepted writes update unlocked entries, legalising cfg as they land
  always_comb begin
    cfg_d   = cfg_q;
    paddr_d = paddr_q;
    if (csr_wr_ok) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (csr_is_cfg && (csr_addr[3:0] == 4'(k / 4)) && !cfg_q[k].l) begin
          cfg_d[k].l = csr_wdata[8*(k%4)+7];
          cfg_d[k].a = pmp_a_e'(csr_wdata[8*(k%4)+3 +: 2]);
          cfg_d[k].x = csr_wdata[8*(k%4)+2];
          cfg_d[k].w = csr_wdata[8*(k%4)+1] & csr_wdata[8*(k%4)];
          cfg_d[k].r = csr_wdata[8*(k%4)];
        end
        if (csr_is_addr && (csr_addr[3:0] == 4'(k)) && !addr_lock[k]) begin
          paddr_d[k] = csr_wdata;
        end
      end
    end
  end

  // Combinational readback; unmapped addresses read as zero
  always_comb begin
    csr_rdata = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (csr_is_cfg && (csr_addr[3:0] == 4'(k / 4))) begin
        csr_rdata[8*(k%4) +: 8] = cfg_to_byte(cfg_q[k]);
      end
      if (csr_is_addr && (csr_addr[3:0] == 4'(k))) begin
        csr_rdata = paddr_q[k];
      end
    end
  end

  // PMP register file
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        cfg_q[k]   <= '0;
        paddr_q[k] <= '0;
      end
    end else begin
      cfg_q   <= cfg_d;
      paddr_q <= paddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry evaluation for the current scan index
  // ---------------------------------------------------------------------------
  assign cur_cfg   = cfg_q[idx_q];
  assign cur_addr  = paddr_q[idx_q];
  assign cur_lo    = (idx_q == '0) ? 32'd0 : paddr_q[idx_q - 1'b1];
  assign last_byte = addr_q + ((32'd1 << size_q) - 32'd1);

  pmp_entry_match u_match (
    .a_i          (cur_cfg.a),
    .pmpaddr_i    (cur_addr),
    .pmpaddr_lo_i (cur_lo),
    .first_i      (addr_q),
    .last_i       (last_byte),
    .match_o      (cur_match),
    .partial_o    (cur_partial)
  );

  // Permission bit for the latched access type
  always_comb begin
    perm_bit = 1'b0;
    case (oper_q)
      OPER_READ:  perm_bit = cur_cfg.r;
      OPER_WRITE: perm_bit = cur_cfg.w;
      OPER_EXEC:  perm_bit = cur_cfg.x;
      default:    perm_bit = 1'b0;
    endcase
  end

  assign grant = ((priv_q == PRIV_M) && !cur_cfg.l) || perm_bit;

  // ---------------------------------------------------------------------------
  // Request sequencer
  // ---------------------------------------------------------------------------
  assign req_ready = reset && (state_q == ST_IDLE) && !csr_we;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_perm  = perm_q;
  assign rsp_entry = entry_q;
  assign csr_err   = csr_err_q;

  // Next-state and result computation; first hit or partial ends the scan
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    size_d  = size_q;
    oper_d  = oper_q;
    priv_d  = priv_q;
    perm_d  = perm_q;
    entry_d = entry_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          size_d = req_size;
          oper_d = req_oper;
          priv_d = req_priv;
          idx_d  = '0;
          if (req_oper == OPER_INVALID) begin
            state_d = ST_RESP;
            perm_d  = 2'b00;
            entry_d = NO_ENTRY;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (cur_match) begin
          state_d = ST_RESP;
          perm_d  = grant ? PERM_GRANT : oper_q;
          entry_d = 5'(idx_q);
        end else if (cur_partial) begin
          state_d = ST_RESP;
          perm_d  = oper_q;
          entry_d = 5'(idx_q);
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_RESP;
          perm_d  = (priv_q == PRIV_M) ? PERM_GRANT : oper_q;
          entry_d = NO_ENTRY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and result registers; reset drops any request in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      oper_q    <= '0;
      priv_q    <= '0;
      perm_q    <= '0;
      entry_q   <= '0;
      csr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      oper_q    <= oper_d;
      priv_q    <= priv_d;
      perm_q    <= perm_d;
      entry_q   <= entry_d;
      csr_err_q <= csr_err_d;
    end
  end

endmodule

// File: tb/tb_pmp_check_seq.sv
// tb/tb_pmp_check_seq.sv - self-checking bench for pmp_check_seq
module tb_pmp_check_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        csr_we = 1'b0;
  logic [1:0]  csr_priv = 2'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic [31:0] csr_rdata;
  logic        csr_err;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic [1:0]  req_oper = 2'd0;
  logic [1:0]  req_priv = 2'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_perm;
  logic [4:0]  rsp_entry;

  always #5 clock = ~clock;

  pmp_check_seq #(.NUM_ENTRIES(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .csr_we    (csr_we),
    .csr_priv  (csr_priv),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_err   (csr_err),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_oper  (req_oper),
    .req_priv  (req_priv),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_perm  (rsp_perm),
    .rsp_entry (rsp_entry)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [1:0]  oper;
    logic [1:0]  priv;
    logic [1:0]  perm;
    logic [4:0]  entry;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [1:0] perm;
    logic [4:0] entry;
    int         lat;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d, input logic [1:0] p,
                           input logic exp_err);
    @(negedge clock);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d; csr_priv = p;
    @(negedge clock);
    csr_we = 1'b0;
    check($sformatf("csr_err_wr_%0h", a), csr_err, exp_err);
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clock);
    csr_addr = a;
    #1 d = csr_rdata;
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, d, exp);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                        input logic [1:0] pv, input logic [1:0] ep, input logic [4:0] ee,
                        input int el, input int hold, input string tag);
    exp_t e;
    exp_t got;
    int   w;
    int   n;
    e.perm = ep; e.entry = ee; e.lat = el;
    sbq.push_back(e);
    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_oper = op; req_priv = pv;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_ready"}, req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    got = sbq.pop_front();
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 1'b0, 1'b1);
    end else begin
      check({tag, "_perm"}, rsp_perm, got.perm);
      check({tag, "_entry"}, rsp_entry, got.entry);
      check({tag, "_latency"}, n, got.lat);
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        check({tag, "_hold_valid"}, rsp_valid, 1'b1);
        check({tag, "_hold_perm"}, rsp_perm, got.perm);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, rsp_valid, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int n;

    vecs[0]  = '{addr:32'h0000_0800, size:2, oper:0, priv:0, perm:2'b11, entry:0,  lat:1,  hold:0};
    vecs[1]  = '{addr:32'h0000_0800, size:2, oper:1, priv:0, perm:2'b01, entry:0,  lat:1,  hold:2};
    vecs[2]  = '{addr:32'h0000_0800, size:0, oper:1, priv:3, perm:2'b11, entry:0,  lat:1,  hold:0};
    vecs[3]  = '{addr:32'h0000_2000, size:2, oper:1, priv:1, perm:2'b11, entry:1,  lat:2,  hold:0};
    vecs[4]  = '{addr:32'h0000_2002, size:2, oper:2, priv:0, perm:2'b10, entry:1,  lat:2,  hold:0};
    vecs[5]  = '{addr:32'h0000_2800, size:1, oper:2, priv:0, perm:2'b11, entry:2,  lat:3,  hold:1};
    vecs[6]  = '{addr:32'h0000_2800, size:1, oper:0, priv:0, perm:2'b00, entry:2,  lat:3,  hold:0};
    vecs[7]  = '{addr:32'h0000_0FFE, size:2, oper:0, priv:0, perm:2'b00, entry:0,  lat:1,  hold:0};
    vecs[8]  = '{addr:32'h0000_5000, size:0, oper:0, priv:0, perm:2'b00, entry:16, lat:16, hold:0};
    vecs[9]  = '{addr:32'h0000_5000, size:0, oper:1, priv:3, perm:2'b11, entry:16, lat:16, hold:0};
    vecs[10] = '{addr:32'h0000_0800, size:0, oper:3, priv:3, perm:2'b00, entry:16, lat:0,  hold:1};
    vecs[11] = '{addr:32'h0000_3000, size:0, oper:2, priv:1, perm:2'b10, entry:16, lat:16, hold:0};
    vecs[12] = '{addr:32'hFFFF_FFFF, size:1, oper:1, priv:0, perm:2'b01, entry:0,  lat:1,  hold:0};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_perm", rsp_perm, 2'b00);
    check("rst_rsp_entry", rsp_entry, 5'd0);
    check("rst_csr_err", csr_err, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", req_ready, 1'b1);
    read_check("rst_cfg0", 12'h3A0, 32'h0);
    read_check("rst_addr0", 12'h3B0, 32'h0);
    read_check("unmapped", 12'h3C0, 32'h0);

    // All entries OFF: full scan, M granted, S denied
    do_req(32'h1000, 2'd0, 2'd2, 2'd1, 2'b10, 5'd16, 16, 0, "off_s_exec");
    do_req(32'h1000, 2'd0, 2'd2, 2'd3, 2'b11, 5'd16, 16, 2, "off_m_exec");

    // CSR write while scanning is dropped with an error pulse
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h5000; req_size = 2'd0; req_oper = 2'd0; req_priv = 2'd0;
    check("scanwr_ready", req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    csr_write(12'h3B5, 32'hAB, 2'd3, 1'b1);
    @(negedge clock);
    check("scanwr_err_clear", csr_err, 1'b0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("scanwr_entry", rsp_entry, 5'd16);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    read_check("scanwr_addr5", 12'h3B5, 32'h0);

    // Table configuration: TOR R, NA4 RWX, TOR X
    csr_write(12'h3B0, 32'h400, 2'd3, 1'b0);
    csr_write(12'h3B1, 32'h800, 2'd3, 1'b0);
    csr_write(12'h3B2, 32'hC00, 2'd3, 1'b0);
    csr_write(12'h3A0, 32'h000C_1709, 2'd3, 1'b0);
    read_check("cfg0_rb", 12'h3A0, 32'h000C_1709);
    csr_write(12'h3A1, 32'h0000_006A, 2'd3, 1'b0);
    read_check("cfg1_legal", 12'h3A1, 32'h0000_0008);
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].addr, vecs[i].size, vecs[i].oper, vecs[i].priv, vecs[i].perm,
             vecs[i].entry, vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // NAPOT 4 KiB region at 0 on entry 3, X only
    apply_reset();
    csr_write(12'h3B3, 32'h1FF, 2'd3, 1'b0);
    csr_write(12'h3A0, 32'h1C00_0000, 2'd3, 1'b0);
    read_check("napot_cfg_rb", 12'h3A0, 32'h1C00_0000);
`ifdef PMP_NAPOT_EN
    do_req(32'h0FFE, 2'd2, 2'd2, 2'd0, 2'b10, 5'd3, 4, 0, "napot_partial");
    do_req(32'h0800, 2'd2, 2'd2, 2'd0, 2'b11, 5'd3, 4, 0, "napot_full");
`else
    do_req(32'h0FFE, 2'd2, 2'd2, 2'd0, 2'b10, 5'd16, 16, 0, "napot_partial");
    do_req(32'h0800, 2'd2, 2'd2, 2'd0, 2'b10, 5'd16, 16, 0, "napot_full");
`endif

    // Locked TOR entry 2 protects pmpaddr1 and pmpaddr2
    apply_reset();
    csr_write(12'h3B1, 32'h33, 2'd3, 1'b0);
    csr_write(12'h3A0, 32'h0088_0000, 2'd3, 1'b0);
    csr_write(12'h3B1, 32'h55, 2'd3, 1'b0);
    read_check("lock_addr1", 12'h3B1, 32'h33);
    csr_write(12'h3B2, 32'h77, 2'd3, 1'b0);
    read_check("lock_addr2", 12'h3B2, 32'h0);
    csr_write(12'h3A0, 32'h0000_0F0B, 2'd3, 1'b0);
    read_check("lock_cfg_byte", 12'h3A0, 32'h0088_0F0B);
    csr_write(12'h3B0, 32'h99, 2'd0, 1'b1);
    @(negedge clock);
    check("upriv_err_pulse_end", csr_err, 1'b0);
    read_check("upriv_addr0", 12'h3B0, 32'h0);

    // Reset while scanning entry 5 aborts with no response
    apply_reset();
    csr_write(12'h3B0, 32'h123, 2'd3, 1'b0);
    csr_write(12'h3A0, 32'h0000_0009, 2'd3, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h5000; req_size = 2'd0; req_oper = 2'd0; req_priv = 2'd0;
    check("abort_ready", req_ready, 1'b1);
    @(posedge clock);
    repeat (5) @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_req_ready", req_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    check("abort_no_rsp", seen, 0);
    read_check("abort_cfg0", 12'h3A0, 32'h0);
    read_check("abort_addr0", 12'h3B0, 32'h0);

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
